conv_result_collector: RTL
==========================

// Module: conv_result_collector
// PURPOSE
//  Downstream end of the matrix_convol result stream: captures each 16-bit result strobed by
//  out/done and rebuilds the output feature map in a local buffer. Once the map is complete it
//  drains it to the next stage over a valid/ready read port, row-major, tagged with row/col/last.
// PARAMETERS
//  M     3   image side; must match the producer's m
//  F     2   kernel side; must match the producer's f; F <= M
//  MAXN  (M-F+1)*(M-F+1)  buffer depth (16-bit words), i.e. the stride-1 map size
// PORTS
//  clk       in   1   single clock; all flops on posedge
//  rst       in   1   asynchronous, active-low reset
//  start     in   1   one-cycle pulse: arm the collector for a new map
//  stride    in   4   stride used by the producer for this map; sampled on start
//  in_data   in   16  result word (producer out)
//  in_done   in   1   result strobe (producer done); one word per high cycle
//  rd_valid  out  1   rd_data/rd_row/rd_col/rd_last are valid
//  rd_ready  in   1   consumer accepts the word when rd_valid && rd_ready
//  rd_data   out  16  result word
//  rd_row    out  4   output-map row of rd_data
//  rd_col    out  4   output-map column of rd_data
//  rd_last   out  1   high with the final word of the map
//  busy      out  1   high in COLLECT or DRAIN
//  overrun   out  1   sticky: in_done seen outside COLLECT; cleared by start or reset
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; rd_valid, rd_data, rd_row, rd_col, rd_last, busy, overrun
//    all 0; write/read pointers 0. Buffer contents are not reset. Reset mid-operation aborts
//    immediately; no partial drain.
//  - Map size on start: S = (stride==0) ? 1 : stride; O = (M-F)/S + 1 (integer divide);
//    N = O*O, latched in registers. O is computed with combinational divide or a small table.
//  - FSM IDLE -> COLLECT on start. COLLECT: each in_done writes in_data to buf[wptr], wptr++.
//    The cycle the N-th word is written, the FSM moves to DRAIN; rd_valid rises the next cycle.
//  - DRAIN: rd_data = buf[rptr], rd_row = rptr / O, rd_col = rptr % O (counters, no divider),
//    rd_last = (rptr == N-1). Outputs are registered and held stable while rd_valid && !rd_ready.
//    On a handshake rptr++ and the next word appears the following cycle (one word per cycle
//    under continuous rd_ready). The handshake with rd_last returns the FSM to IDLE and drops
//    rd_valid in that same edge.
//  - start while COLLECT or DRAIN: restart, i.e. pointers cleared, overrun cleared, new stride
//    latched, FSM in COLLECT; any unread words are discarded.
//  - start together with in_done in IDLE: start wins, and the word is also captured as word 0.
//  - in_done in IDLE or DRAIN: word dropped, overrun set.
//  - Widths: pointers use $clog2(MAXN+1) bits; O <= M-F+1 <= 15, so 4-bit row/col suffices.
// CONFIGURATION
//  CONV_MAXPOOL_EN defined: adds output max_val[15:0] and output max_valid.
//    max_val is the unsigned running max of the words captured in COLLECT, cleared to 0 on start.
//    max_valid goes high on entry to DRAIN and clears on start or reset.
//    max_val is 0 after reset.
//  CONV_MAXPOOL_EN undefined: the two ports and the comparator are absent; all other behaviour
//    is identical.
// TESTING
//  M=3,F=2,stride=1; start; in_done with 10,20,30,40; rd_ready=1 -> drains 10,20,30,40 with
//    (row,col) = (0,0),(0,1),(1,0),(1,1); rd_last only on 40; busy falls after the last handshake.
//  stride=2; start; in_done with 0x1234 -> O=1: a single word 0x1234, row 0, col 0, rd_last=1.
//  stride=0 -> behaves as stride=1 (N=4). Backpressure: rd_ready low for 3 cycles on word 2 ->
//    rd_data stays 30 with rd_valid high; no word is lost or duplicated.
//  in_done during DRAIN and in IDLE -> overrun=1 and buffer unchanged; next start clears overrun.
//  rst asserted after 2 of 4 writes -> all outputs 0 immediately; a fresh start then collects
//    4 new words correctly.
//  CONV_MAXPOOL_EN: words 7,0xFFFE,3,9 -> max_val=0xFFFE, max_valid=1 at DRAIN entry.

Source files
------------

// File: rtl/conv_result_collector_if.sv
// Result-stream and read-port bundle for conv_result_collector.
// CONV_MAXPOOL_EN adds the max_val/max_valid pair.
interface conv_result_collector_if;
  logic        start;
  logic [3:0]  stride;
  logic [15:0] in_data;
  logic        in_done;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [3:0]  rd_row;
  logic [3:0]  rd_col;
  logic        rd_last;
  logic        busy;
  logic        overrun;
`ifdef CONV_MAXPOOL_EN
  logic [15:0] max_val;
  logic        max_valid;
`endif

  modport master (
    output start, stride, in_data, in_done, rd_ready,
    input  rd_valid, rd_data, rd_row, rd_col, rd_last, busy, overrun
`ifdef CONV_MAXPOOL_EN
    , input max_val, max_valid
`endif
  );

  modport slave (
    input  start, stride, in_data, in_done, rd_ready,
    output rd_valid, rd_data, rd_row, rd_col, rd_last, busy, overrun
`ifdef CONV_MAXPOOL_EN
    , output max_val, max_valid
`endif
  );
endinterface

// File: rtl/conv_result_collector.sv
// Collects one convolution output map from the producer strobe, then drains it row-major.
// Optional feature macro: CONV_MAXPOOL_EN (running unsigned max of the collected words).
module conv_result_collector #(
  parameter int M    = 3,
  parameter int F    = 2,
  parameter int MAXN = (M - F + 1) * (M - F + 1)
) (
  input logic                    clk,
  input logic                    rst,
  conv_result_collector_if.slave bus
);
  localparam int         PW    = $clog2(MAXN + 1);
  localparam int         DEPTH = 1 << PW;
  localparam logic [3:0] SPAN  = 4'(M - F);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   nCount_q, nCount_d;
  logic [3:0]      oSize_q, oSize_d;
  logic            rdValid_q, rdValid_d;
  logic [15:0]     rdData_q, rdData_d;
  logic [3:0]      rdRow_q, rdRow_d;
  logic [3:0]      rdCol_q, rdCol_d;
  logic            rdLast_q, rdLast_d;
  logic            overrun_q, overrun_d;
  logic            enterDrain;
  logic            memWe;
  logic [PW-1:0]   memAddr;
  logic [15:0]     mem [DEPTH];

  logic [3:0]      strideEff;
  logic [3:0]      oCalc;
  logic [PW-1:0]   nCalc;

  // Output-map geometry for the stride presented with start
  assign strideEff = (bus.stride == 4'd0) ? 4'd1 : bus.stride;
  assign oCalc     = SPAN / strideEff + 4'd1;
  assign nCalc     = PW'(oCalc) * PW'(oCalc);

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    nCount_d   = nCount_q;
    oSize_d    = oSize_q;
    rdValid_d  = rdValid_q;
    rdData_d   = rdData_q;
    rdRow_d    = rdRow_q;
    rdCol_d    = rdCol_q;
    rdLast_d   = rdLast_q;
    overrun_d  = overrun_q;
    enterDrain = 1'b0;
    memWe      = 1'b0;
    memAddr    = wrPtr_q;

    if (bus.start) begin
      nCount_d  = nCalc;
      oSize_d   = oCalc;
      rdPtr_d   = '0;
      rdValid_d = 1'b0;
      rdLast_d  = 1'b0;
      overrun_d = 1'b0;
      // A word arriving with start becomes word 0 of the new map
      if (bus.in_done) begin
        memWe   = 1'b1;
        memAddr = '0;
        wrPtr_d = PW'(1);
        if (nCalc == PW'(1)) begin
          state_d    = DRAIN;
          enterDrain = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end else begin
        wrPtr_d = '0;
        state_d = COLLECT;
      end
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bus.in_done) begin
            memWe   = 1'b1;
            wrPtr_d = wrPtr_q + PW'(1);
            if (wrPtr_d == nCount_q) begin
              state_d    = DRAIN;
              rdPtr_d    = '0;
              enterDrain = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.in_done) overrun_d = 1'b1;
          // rdPtr always names the word currently presented on the read port
          if (!rdValid_q) begin
            rdValid_d = 1'b1;
            rdData_d  = mem[rdPtr_q];
            rdRow_d   = 4'd0;
            rdCol_d   = 4'd0;
            rdLast_d  = (rdPtr_q == nCount_q - PW'(1));
          end else if (bus.rd_ready) begin
            if (rdLast_q) begin
              state_d   = IDLE;
              rdValid_d = 1'b0;
              rdLast_d  = 1'b0;
            end else begin
              rdPtr_d  = rdPtr_q + PW'(1);
              rdData_d = mem[rdPtr_d];
              rdLast_d = (rdPtr_d == nCount_q - PW'(1));
              if (rdCol_q == oSize_q - 4'd1) begin
                rdCol_d = 4'd0;
                rdRow_d = rdRow_q + 4'd1;
              end else begin
                rdCol_d = rdCol_q + 4'd1;
              end
            end
          end
        end
        default: begin
          if (bus.in_done) overrun_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      nCount_q  <= '0;
      oSize_q   <= 4'd0;
      rdValid_q <= 1'b0;
      rdData_q  <= 16'd0;
      rdRow_q   <= 4'd0;
      rdCol_q   <= 4'd0;
      rdLast_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      nCount_q  <= nCount_d;
      oSize_q   <= oSize_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      rdRow_q   <= rdRow_d;
      rdCol_q   <= rdCol_d;
      rdLast_q  <= rdLast_d;
      overrun_q <= overrun_d;
    end
  end

  // Map storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= bus.in_data;
  end

  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = rdData_q;
  assign bus.rd_row   = rdRow_q;
  assign bus.rd_col   = rdCol_q;
  assign bus.rd_last  = rdLast_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overrun  = overrun_q;

`ifdef CONV_MAXPOOL_EN
  logic [15:0] maxVal_q, maxVal_d;
  logic        maxValid_q, maxValid_d;

  always_comb begin
    maxVal_d   = maxVal_q;
    maxValid_d = maxValid_q | enterDrain;
    if (bus.start) begin
      maxVal_d   = bus.in_done ? bus.in_data : 16'd0;
      maxValid_d = enterDrain;
    end else if (state_q == COLLECT && bus.in_done && bus.in_data > maxVal_q) begin
      maxVal_d = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maxVal_q   <= 16'd0;
      maxValid_q <= 1'b0;
    end else begin
      maxVal_q   <= maxVal_d;
      maxValid_q <= maxValid_d;
    end
  end

  assign bus.max_val   = maxVal_q;
  assign bus.max_valid = maxValid_q;
`endif
endmodule
